// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, opcode/func constants and FSM state type for the fetch stage.
package fetch_pkg;
    localparam int INSTR_W = 9;
    localparam logic [2:0] OP_FUNCA = 3'b110;
    localparam logic [2:0] OP_FUNCB = 3'b111;
    localparam logic [2:0] FN_HALT = 3'b111;
    localparam logic [2:0] FN_BNO = 3'b000;
    localparam logic [2:0] FN_BOF = 3'b001;
    typedef enum logic [1:0] {IDLE, RUN, HALTED} fetch_state_t;
endpackage

// File: rtl/fetch_if.sv
// fetch_if: ROM address/instruction path plus ALU overflow feedback around the fetch stage.
interface fetch_if #(parameter int PC_W = 10);
    import fetch_pkg::*;
    logic [PC_W-1:0] pc_out;
    logic [INSTR_W-1:0] instr_in;
    logic [INSTR_W-1:0] instr_out;
    logic ov_in;
    logic ov_we;
    logic flag;
    modport master(input instr_in, ov_in, ov_we, output pc_out, instr_out, flag);
    modport slave(output instr_in, ov_in, ov_we, input pc_out, instr_out, flag);
endinterface

// File: rtl/fetch_branch_lut.sv
// branch_lut: constant table of signed branch offsets indexed by instr[2:0].
module branch_lut (
    input  logic [2:0]        idx,
    output logic signed [7:0] off
);
    localparam logic signed [7:0] LUT [8] = '{8'sd2, 8'sd4, -8'sd2, -8'sd4, 8'sd8, -8'sd8, 8'sd16, -8'sd16};
    assign off = LUT[idx];
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC/fetch stage with overflow flag, BNO/BOF branches and HALT sequencing.
// Optional RUN-cycle counter enabled by FETCH_CYCLE_COUNTER_EN.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int PC_W = 10,
    parameter logic [PC_W-1:0] START_ADDR = '0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    fetch_if.master     bus,
    output logic        running,
    output logic        done,
    output logic [15:0] cycle_count
);
    fetch_state_t state, state_n;
    logic [PC_W-1:0] pc, pc_n;
    logic flag, flag_n;
    logic signed [7:0] off;
    logic [2:0] op, fn;
    logic is_halt, taken;
    branch_lut u_lut (.idx(bus.instr_in[2:0]), .off(off));
    assign op = bus.instr_in[8:6];
    assign fn = bus.instr_in[5:3];
    assign is_halt = (op == OP_FUNCA) && (fn == FN_HALT);
    // branches always see the pre-edge flag, even when ov_we updates it this cycle
    assign taken = (op == OP_FUNCB) && (((fn == FN_BNO) && !flag) || ((fn == FN_BOF) && flag));
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            pc <= '0;
            flag <= 1'b0;
        end else begin
            state <= state_n;
            pc <= pc_n;
            flag <= flag_n;
        end
    end
    always_comb begin
        state_n = state;
        pc_n = pc;
        flag_n = flag;
        if (state == RUN) begin
            flag_n = bus.ov_we ? bus.ov_in : flag;
            state_n = is_halt ? HALTED : RUN;
            pc_n = is_halt ? pc : (taken ? pc + PC_W'(off) : pc + PC_W'(1));
        end else if (start) begin
            state_n = RUN;
            pc_n = START_ADDR;
        end
    end
    assign running = (state == RUN);
    assign done = (state == HALTED);
    assign bus.pc_out = pc;
    assign bus.instr_out = bus.instr_in;
    assign bus.flag = flag;
`ifdef FETCH_CYCLE_COUNTER_EN
    logic [15:0] cnt;
    always_ff @(posedge clk) begin
        if (reset || (start && state != RUN))
            cnt <= '0;
        else if (state == RUN && cnt != 16'hFFFF)
            cnt <= cnt + 16'd1;
    end
    assign cycle_count = cnt;
`else
    assign cycle_count = 16'h0000;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed self-checking bench for fetch_unit (PC_W=10 and PC_W=4 instances).
module tb_fetch_unit;
    localparam logic [8:0] NOP  = 9'b000_000_000;
    localparam logic [8:0] HALT = 9'b110_111_000;
    localparam logic [8:0] BOF0 = 9'b111_001_000;
    localparam logic [8:0] BNO2 = 9'b111_000_010;
    localparam logic [8:0] BOF5 = 9'b111_001_101;
    logic clk = 1'b0;
    logic reset, start, start4;
    logic running, done, running4, done4;
    logic [15:0] cycle_count, cycle_count4;
    logic [8:0] rom [1024];
    logic [8:0] rom4 [16];
    int checks = 0;
    int errors = 0;
    fetch_if #(.PC_W(10)) bus ();
    fetch_if #(.PC_W(4)) bus4 ();
    fetch_unit #(.PC_W(10)) dut (
        .clk(clk), .reset(reset), .start(start), .bus(bus),
        .running(running), .done(done), .cycle_count(cycle_count)
    );
    fetch_unit #(.PC_W(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .bus(bus4),
        .running(running4), .done(done4), .cycle_count(cycle_count4)
    );
    assign bus.instr_in = rom[bus.pc_out];
    assign bus4.instr_in = rom4[bus4.pc_out];
    always #5 clk = ~clk;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic clear_rom();
        for (int i = 0; i < 1024; i++) rom[i] = NOP;
    endtask
    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask
    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask
    logic [15:0] cc_exp4, cc_exp10;
    initial begin
`ifdef FETCH_CYCLE_COUNTER_EN
        cc_exp4 = 16'd4;
        cc_exp10 = 16'd10;
`else
        cc_exp4 = 16'd0;
        cc_exp10 = 16'd0;
`endif
        reset = 1'b1; start = 1'b0; start4 = 1'b0;
        bus.ov_in = 1'b0; bus.ov_we = 1'b0; bus4.ov_in = 1'b0; bus4.ov_we = 1'b0;
        clear_rom();
        for (int i = 0; i < 16; i++) rom4[i] = NOP;
        rom4[2] = BOF5;
        rom[3] = HALT;
        step();
        reset = 1'b0;
        chk("rst_pc", 32'(bus.pc_out), 0);
        chk("rst_flag", 32'(bus.flag), 0);
        chk("rst_running", 32'(running), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_cc", 32'(cycle_count), 0);
        step();
        chk("idle_hold_pc", 32'(bus.pc_out), 0);
        chk("idle_running", 32'(running), 0);
        // sequential run then HALT at 3
        do_start();
        chk("seq_running", 32'(running), 1);
        chk("seq_pc0", 32'(bus.pc_out), 0);
        step(); chk("seq_pc1", 32'(bus.pc_out), 1);
        step(); chk("seq_pc2", 32'(bus.pc_out), 2);
        step(); chk("seq_pc3", 32'(bus.pc_out), 3);
        chk("seq_instr_out", 32'(bus.instr_out), 32'(HALT));
        chk("seq_done_before", 32'(done), 0);
        step();
        chk("halt_pc", 32'(bus.pc_out), 3);
        chk("halt_done", 32'(done), 1);
        chk("halt_running", 32'(running), 0);
        chk("halt_cc", 32'(cycle_count), 32'(cc_exp4));
        step();
        chk("halt_hold_pc", 32'(bus.pc_out), 3);
        chk("halt_hold_done", 32'(done), 1);
        do_start();
        chk("restart_pc", 32'(bus.pc_out), 0);
        chk("restart_done", 32'(done), 0);
        chk("restart_running", 32'(running), 1);
        chk("restart_cc", 32'(cycle_count), 0);
        // BOF taken after flag set at pc=1
        clear_rom();
        rom[2] = BOF0; rom[3] = HALT; rom[4] = HALT;
        do_reset();
        do_start();
        step();
        bus.ov_we = 1'b1; bus.ov_in = 1'b1;
        step();
        bus.ov_we = 1'b0;
        chk("bof_at_pc2", 32'(bus.pc_out), 2);
        chk("bof_flag1", 32'(bus.flag), 1);
        step();
        chk("bof_taken_pc", 32'(bus.pc_out), 4);
        step();
        chk("bof_taken_halt", 32'(done), 1);
        // BOF not taken with flag cleared
        do_reset();
        do_start();
        step();
        bus.ov_we = 1'b1; bus.ov_in = 1'b0;
        step();
        bus.ov_we = 1'b0;
        chk("bof_nt_flag0", 32'(bus.flag), 0);
        step();
        chk("bof_nt_pc", 32'(bus.pc_out), 3);
        // BNO index 2 at pc=6, then reset mid-RUN at pc=5
        clear_rom();
        rom[6] = BNO2;
        do_reset();
        do_start();
        repeat (6) step();
        chk("bno_at_pc6", 32'(bus.pc_out), 6);
        step();
        chk("bno_taken_pc", 32'(bus.pc_out), 4);
        step();
        chk("pre_reset_pc5", 32'(bus.pc_out), 5);
        reset = 1'b1; start = 1'b1; bus.ov_we = 1'b1; bus.ov_in = 1'b1;
        step();
        reset = 1'b0; start = 1'b0; bus.ov_we = 1'b0; bus.ov_in = 1'b0;
        chk("midrun_rst_pc", 32'(bus.pc_out), 0);
        chk("midrun_rst_running", 32'(running), 0);
        chk("midrun_rst_done", 32'(done), 0);
        chk("midrun_rst_flag", 32'(bus.flag), 0);
        // ov_we coinciding with BOF: old flag decides
        clear_rom();
        rom[0] = BOF0; rom[1] = BOF0; rom[3] = HALT;
        do_start();
        bus.ov_we = 1'b1; bus.ov_in = 1'b1;
        step();
        bus.ov_we = 1'b0;
        chk("coinc_nt_pc", 32'(bus.pc_out), 1);
        chk("coinc_flag_next", 32'(bus.flag), 1);
        step();
        chk("coinc_then_taken", 32'(bus.pc_out), 3);
        step();
        chk("coinc_halt", 32'(done), 1);
        bus.ov_we = 1'b1; bus.ov_in = 1'b0;
        step();
        bus.ov_we = 1'b0;
        chk("halted_ignores_ov_we", 32'(bus.flag), 1);
        // cycle counter with HALT at 9
        clear_rom();
        rom[9] = HALT;
        do_reset();
        do_start();
        repeat (10) step();
        chk("cc_halt9_done", 32'(done), 1);
        chk("cc_halt9_pc", 32'(bus.pc_out), 9);
        chk("cc_halt9_val", 32'(cycle_count), 32'(cc_exp10));
        do_start();
        chk("cc_cleared", 32'(cycle_count), 0);
        // PC_W=4: BOF -8 wraps backwards, sequential wraps 15 -> 0
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        bus4.ov_we = 1'b1; bus4.ov_in = 1'b1;
        step();
        bus4.ov_we = 1'b0;
        chk("w4_flag", 32'(bus4.flag), 1);
        step();
        chk("w4_pc2", 32'(bus4.pc_out), 2);
        step();
        chk("w4_branch_pc10", 32'(bus4.pc_out), 10);
        repeat (5) step();
        chk("w4_pc15", 32'(bus4.pc_out), 15);
        step();
        chk("w4_wrap_pc0", 32'(bus4.pc_out), 0);
        chk("w4_running", 32'(running4), 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Program-counter and fetch stage that sits directly upstream of the 8-bit ALU.
- Drives the instruction ROM address and presents the fetched 9-bit instruction downstream. Its bits [8:3] are the ALU's 6-bit OPCODE: op = [8:6], func = [5:3].
- Owns the registered overflow flag produced by the ALU, and resolves B-type branches (BNO/BOF) and HALT.
- Provides start/done program sequencing for the testbench and top level.

Parameters:
- PC_W, 10, program-counter width in bits; ROM depth is 2^PC_W.
- START_ADDR, 0, PC value loaded when a program is launched.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that launches a program from START_ADDR.
- instr_in  input  9  instruction read combinationally from the ROM at pc_out.
- ov_in  input  1  overflow/compare bit from the ALU.
- ov_we  input  1  from control; latch ov_in into the flag this cycle.
- pc_out  output  PC_W  current PC, the ROM address.
- instr_out  output  9  instr_in passed through to decode/ALU.
- flag  output  1  registered overflow flag.
- running  output  1  high while in RUN.
- done  output  1  high while in HALTED.
- cycle_count  output  16  RUN-cycle count (see Optional Feature).

Behaviour:
- Reset: this is one clock, synchronous, active-high; the reset port is named `reset` and the clock `clk`.
- Values after reset: state=IDLE, pc_out=0, flag=0, running=0, done=0, cycle_count=0. Reset wins over every other input in the same cycle, including mid-RUN; the FSM goes to IDLE with no partial PC update.
- FSM states: IDLE, RUN, HALTED (2-bit encoding).
- IDLE: pc holds. On start, go to RUN and set pc=START_ADDR.
- RUN: each cycle, decode instr_in at the current pc.
  - HALT (op=3'b110, func=3'b111): go to HALTED, pc holds at the HALT address, done=1 from the next cycle.
  - B-type (op=3'b111), func=BNO (3'b000): taken if flag==0.
  - B-type, func=BOF (3'b001): taken if flag==1.
  - Taken branch: pc_next = pc + sext(branch_lut[instr_in[2:0]]).
  - Not taken, other B-type func values, and all non-branch instructions: pc_next = pc + 1.
  - PC arithmetic is modulo 2^PC_W; pc = 2^PC_W-1 with sequential increment wraps to 0. Branch targets wrap the same way.
  - start is ignored.
- HALTED: pc and flag hold. On start, go to RUN with pc=START_ADDR and done cleared the same edge.
- Flag:
  - When ov_we=1 in RUN: flag <= ov_in.
  - Outside RUN, ov_we is ignored.
  - A branch always samples the registered (pre-edge) flag. If ov_we and a branch coincide, the branch uses the old flag and the new flag becomes visible next cycle.
- Latency: the branch decision is made in the same cycle the branch is at pc_out. The new pc appears after 1 clock, with no delay slot.
- instr_out = instr_in, combinational, in every state.

Optional Feature:
- Macro: FETCH_CYCLE_COUNTER_EN.
- Defined: 16-bit cycle_count.
  - Cleared on reset and on each accepted start.
  - Increments every cycle spent in RUN, including the HALT-decode cycle.
  - Saturates at 16'hFFFF.
  - Holds in IDLE/HALTED.
- Undefined: cycle_count is tied to 16'h0000 and no counter logic is generated.

Decomposition:
- Package fetch_pkg holds:
  - INSTR_W=9.
  - Op constants OP_FUNCA=3'b110, OP_FUNCB=3'b111.
  - Func constants FN_HALT=3'b111, FN_BNO=3'b000, FN_BOF=3'b001.
  - Enum fetch_state_t {IDLE, RUN, HALTED}.
- Sub-module branch_lut: combinational, 3-bit index in, 8-bit signed offset out, with 8 constant entries.
  - Entries 0-3 = +2, +4, -2, -4; entries 4-7 = +8, -8, +16, -16.

Test Plan:
- Reset mid-RUN at pc=5 -> next cycle pc_out=0, running=0, done=0, flag=0.
- start with ROM of non-branch ops then HALT at 3 -> pc_out sequence 0,1,2,3,3; done=1 from the cycle after pc=3 is presented; running low thereafter.
- Branch on the flag, with ov_we=1 and ov_in=1 at pc=1:
  - BOF index 0 at pc=2 -> pc=4.
  - Repeat with ov_in=0 -> pc=3.
  - BNO index 2 at pc=6 with flag=0 -> pc=4.
- ov_we=1, ov_in=1 in the same cycle as BOF (flag was 0) -> not taken (pc+1); flag=1 on the next cycle.
- PC_W=4, sequential ROM, no HALT until wrap: pc 15 -> 0. BOF index 5 (-8) at pc=2 with flag=1 -> pc=10.
- With FETCH_CYCLE_COUNTER_EN, HALT at address 9 -> cycle_count=10 in HALTED. A new start clears it to 0.
